knight_anim_sequencer: RTL and testbench
========================================

Name: knight_anim_sequencer

Overview:
Sequences the knight walk animation and generates per-pixel addresses into the 50x64 knight sprite ROMs during scan-out. It decides which walk frame is shown and when it advances. It places the sprite at a latched screen position, mirrors it for left-facing motion, and flags which pixels belong to the sprite. It sits between the game logic (position, walking, facing inputs) and the sprite ROM/palette path. The top-level colour mux consumes its outputs.

Parameters:
SPR_W, 50, sprite width in pixels
SPR_H, 64, sprite height in pixels
NUM_FRAMES, 4, walk frames in the cycle
FRAME_HOLD, 6, frame_start pulses each walk frame is displayed
ADDR_W, 12, ROM address width (SPR_W*SPR_H <= 2^ADDR_W)

Ports:
vga_clk  in  1  pixel clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
walking  in  1  game logic requests walk animation
facing_left  in  1  1 = mirror sprite horizontally
KnightX  in  10  sprite left edge, screen coords
KnightY  in  10  sprite top edge, screen coords
DrawX  in  10  current scan pixel X
DrawY  in  10  current scan pixel Y
rom_address  out  ADDR_W  address into selected walk-frame ROM
frame_sel  out  $clog2(NUM_FRAMES)  active walk frame index
sprite_on  out  1  current rom_address is a sprite pixel
anim_state  out  2  00 IDLE, 01 WALK, 10 STOP

Behaviour:
- Reset (synchronous, dominates all other inputs): state IDLE, frame_sel 0, hold_cnt 0, latched X/Y/facing 0, rom_address 0, sprite_on 0.
- All animation state, latched position and latched facing change only on cycles with frame_start=1. This prevents mid-frame tearing.
- On every frame_start, latch KnightX, KnightY and facing_left, in every state.
- IDLE:
  - frame_sel held 0, hold_cnt 0.
  - frame_start & walking -> WALK, hold_cnt 0, frame_sel 0.
- WALK:
  - On frame_start & walking: if hold_cnt==FRAME_HOLD-1, set hold_cnt 0 and frame_sel (frame_sel+1) mod NUM_FRAMES. Otherwise hold_cnt+1.
  - On frame_start & !walking -> STOP, with the same hold_cnt/frame_sel update applied.
- STOP (finish the current frame's hold, then rest):
  - On frame_start, if hold_cnt==FRAME_HOLD-1 -> IDLE, frame_sel 0, hold_cnt 0. Otherwise hold_cnt+1.
  - walking is ignored in STOP; the walk is re-entered only via IDLE.
- walking is sampled only on frame_start; toggles between pulses have no effect.
- Address path, latency 1 cycle from DrawX/DrawY:
  - rx = DrawX - latched X and ry = DrawY - latched Y, each computed as 11-bit two's complement.
  - hit = (0<=rx<SPR_W) && (0<=ry<SPR_H).
  - col = facing ? SPR_W-1-rx : rx.
  - Registered outputs: sprite_on <= hit; rom_address <= hit ? ry*SPR_W+col : 0.
  - Right/bottom clipping falls out of the bounds check. No wrap-around: negative rx/ry never hit.
- rom_address and sprite_on are mutually aligned. The ROM is read on the negedge, so q is valid for the consumer's next posedge.
- frame_sel and anim_state are registered state outputs.

Test Plan:
- Reset, frame_start pulses with walking=0 -> anim_state 00, frame_sel 0 throughout.
- walking=1, 30 frame_start pulses (FRAME_HOLD=6) -> IDLE->WALK on pulse 1. frame_sel advances on pulses 7, 13, 19, 25 (1,2,3,0).
- Latched X=100, Y=200, facing=0; DrawX=100, DrawY=200 -> next cycle sprite_on 1, rom_address 0. DrawX=149, DrawY=263 -> 3199. DrawX=150 -> sprite_on 0, rom_address 0.
- facing=1 latched; DrawX=100, DrawY=201 -> rom_address 99. Change KnightX to 300 mid-frame, no frame_start -> addresses unchanged.
- In WALK with hold_cnt=2, frame_start with walking=0 -> STOP. Three more pulses -> IDLE, frame_sel 0. A walking pulse between frame_starts is ignored.
- Reset asserted mid-WALK on the same cycle as frame_start -> next cycle IDLE, frame_sel 0, sprite_on 0.

Source files
------------

// File: rtl/knight_anim_sequencer.sv
// Knight walk-animation sequencer and sprite ROM address generator.
// Animation state and the latched sprite position only change on frame_start so a scan-out never tears.
module knight_anim_sequencer #(
  parameter int SPR_W      = 50,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = 12,
  localparam int FS_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              walking,
  input  logic              facing_left,
  input  logic [9:0]        KnightX,
  input  logic [9:0]        KnightY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_address,
  output logic [FS_W-1:0]   frame_sel,
  output logic              sprite_on,
  output logic [1:0]        anim_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    STOP = 2'b10
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [9:0]        lx;
  logic [9:0]        ly;
  logic              lfacing;

  logic              hold_wrap;
  logic [HOLD_W-1:0] hold_step;
  logic [FS_W-1:0]   fs_step;

  // Shared hold/frame advance used by both WALK and the WALK->STOP transition.
  always_comb begin
    hold_wrap = (hold_cnt == HOLD_W'(FRAME_HOLD - 1));
    hold_step = hold_wrap ? '0 : hold_cnt + 1'b1;
    fs_step   = frame_sel;
    if (hold_wrap) begin
      fs_step = (frame_sel == FS_W'(NUM_FRAMES - 1)) ? '0 : frame_sel + 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state     <= IDLE;
      frame_sel <= '0;
      hold_cnt  <= '0;
      lx        <= '0;
      ly        <= '0;
      lfacing   <= 1'b0;
    end else if (frame_start) begin
      lx      <= KnightX;
      ly      <= KnightY;
      lfacing <= facing_left;
      case (state)
        IDLE: begin
          frame_sel <= '0;
          hold_cnt  <= '0;
          if (walking) state <= WALK;
        end
        WALK: begin
          hold_cnt  <= hold_step;
          frame_sel <= fs_step;
          if (!walking) state <= STOP;
        end
        STOP: begin
          if (hold_wrap) begin
            state     <= IDLE;
            frame_sel <= '0;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          frame_sel <= '0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  assign anim_state = state;

  logic [10:0]       rx;
  logic [10:0]       ry;
  logic [10:0]       col;
  logic              hit;
  logic [ADDR_W-1:0] addr_calc;

  // 11-bit two's complement offsets: a set sign bit means left of / above the sprite, never a hit.
  always_comb begin
    rx        = {1'b0, DrawX} - {1'b0, lx};
    ry        = {1'b0, DrawY} - {1'b0, ly};
    hit       = !rx[10] && (rx < 11'(SPR_W)) && !ry[10] && (ry < 11'(SPR_H));
    col       = lfacing ? (11'(SPR_W - 1) - rx) : rx;
    addr_calc = ADDR_W'(ry) * ADDR_W'(SPR_W) + ADDR_W'(col);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      sprite_on   <= 1'b0;
      rom_address <= '0;
    end else begin
      sprite_on   <= hit;
      rom_address <= hit ? addr_calc : '0;
    end
  end

endmodule

// File: tb/tb_knight_anim_sequencer.sv
// Directed bench for knight_anim_sequencer: animation sequencing, address mapping, mirroring and reset.
module tb_knight_anim_sequencer;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        walking;
  logic        facing_left;
  logic [9:0]  KnightX;
  logic [9:0]  KnightY;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [11:0] rom_address;
  logic [1:0]  frame_sel;
  logic        sprite_on;
  logic [1:0]  anim_state;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  knight_anim_sequencer dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .walking     (walking),
    .facing_left (facing_left),
    .KnightX     (KnightX),
    .KnightY     (KnightY),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_address (rom_address),
    .frame_sel   (frame_sel),
    .sprite_on   (sprite_on),
    .anim_state  (anim_state)
  );

  // Inputs change 1 ns after the active edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_anim(input string tag, input logic [1:0] st, input logic [1:0] fs);
    check({tag, "_state"}, 32'(anim_state), 32'(st));
    check({tag, "_fsel"}, 32'(frame_sel), 32'(fs));
  endtask

  task automatic check_pix(input string tag, input logic on, input logic [11:0] addr);
    check({tag, "_on"}, 32'(sprite_on), 32'(on));
    check({tag, "_addr"}, 32'(rom_address), 32'(addr));
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; walking = 1'b0; facing_left = 1'b0;
    KnightX = 10'd0; KnightY = 10'd0; DrawX = 10'd700; DrawY = 10'd700;
    step(); step();
    check_anim("reset", 2'b00, 2'd0);
    check_pix("reset", 1'b0, 12'd0);

    // Idle pulses with walking low stay in IDLE.
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse(); step();
      check_anim("idle_pulse", 2'b00, 2'd0);
    end

    // Walk cycle: frame_sel advances on pulses 7, 13, 19, 25.
    KnightX = 10'd100; KnightY = 10'd200; facing_left = 1'b0; walking = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      pulse();
      check_anim($sformatf("walk_p%0d", k), 2'b01, 2'(((k - 1) / 6) % 4));
      step();
    end

    // Address mapping, right-facing.
    DrawX = 10'd100; DrawY = 10'd200; step();
    check_pix("tl_corner", 1'b1, 12'd0);
    DrawX = 10'd149; DrawY = 10'd263; step();
    check_pix("br_corner", 1'b1, 12'd3199);
    DrawX = 10'd150; step();
    check_pix("right_clip", 1'b0, 12'd0);
    DrawX = 10'd99; DrawY = 10'd200; step();
    check_pix("left_neg", 1'b0, 12'd0);
    DrawX = 10'd120; DrawY = 10'd264; step();
    check_pix("bottom_clip", 1'b0, 12'd0);
    DrawX = 10'd110; DrawY = 10'd203; step();
    check_pix("interior", 1'b1, 12'd160);

    // Pulse 31 latches facing_left; hold wraps so frame_sel goes to 1.
    facing_left = 1'b1;
    pulse();
    check_anim("walk_p31", 2'b01, 2'd1);
    DrawX = 10'd100; DrawY = 10'd201; step();
    check_pix("mirror_left", 1'b1, 12'd99);
    KnightX = 10'd300;
    step(); step();
    check_pix("no_midframe_latch", 1'b1, 12'd99);
    DrawX = 10'd149; DrawY = 10'd200; step();
    check_pix("mirror_right", 1'b1, 12'd0);

    // Two more walking pulses bring hold_cnt to 2, then walking drops.
    KnightX = 10'd100;
    pulse(); step();
    pulse(); step();
    check_anim("walk_hold2", 2'b01, 2'd1);
    walking = 1'b0;
    pulse();
    check_anim("to_stop", 2'b10, 2'd1);
    step();
    pulse();
    check_anim("stop_1", 2'b10, 2'd1);
    walking = 1'b1; step(); walking = 1'b0; step();
    walking = 1'b1;
    pulse();
    check_anim("stop_2_walk_ignored", 2'b10, 2'd1);
    walking = 1'b0; step();
    pulse();
    check_anim("stop_to_idle", 2'b00, 2'd0);
    step();
    walking = 1'b1; step(); step(); walking = 1'b0; step();
    check_anim("idle_glitch_ignored", 2'b00, 2'd0);
    pulse(); step();
    check_anim("idle_stays", 2'b00, 2'd0);

    // Enter WALK, show a sprite pixel, then reset together with frame_start.
    facing_left = 1'b0; KnightY = 10'd200; walking = 1'b1;
    pulse();
    check_anim("rewalk", 2'b01, 2'd0);
    DrawX = 10'd100; DrawY = 10'd200; step();
    check_pix("pre_reset", 1'b1, 12'd0);
    Reset = 1'b1; frame_start = 1'b1;
    step();
    Reset = 1'b0; frame_start = 1'b0; walking = 1'b0;
    check_anim("reset_mid_walk", 2'b00, 2'd0);
    check_pix("reset_mid_walk", 1'b0, 12'd0);
    DrawX = 10'd5; DrawY = 10'd1; step();
    check_pix("post_reset_origin", 1'b1, 12'd55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
